// File: rtl/sevensegment_pkg.sv
// sevensegment_scan shared definitions
// segment bit positions and hex-to-segment decode
package sevensegment_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = 7;

  function automatic logic [SEG_W-1:0] seg_bits(
    input logic a, input logic b, input logic c,
    input logic d, input logic e, input logic f,
    input logic g
  );
    logic [SEG_W-1:0] s;
    s = '0;
    s[SEG_A] = a;
    s[SEG_B] = b;
    s[SEG_C] = c;
    s[SEG_D] = d;
    s[SEG_E] = e;
    s[SEG_F] = f;
    s[SEG_G] = g;
    return s;
  endfunction

  // active-high glyphs, bit0=a .. bit6=g
  function automatic logic [SEG_W-1:0] hex2seg(
    input logic [3:0] h
  );
    logic [SEG_W-1:0] s;
    s = '0;
    case (h)
      4'h0: s = seg_bits(1,1,1,1,1,1,0);
      4'h1: s = seg_bits(0,1,1,0,0,0,0);
      4'h2: s = seg_bits(1,1,0,1,1,0,1);
      4'h3: s = seg_bits(1,1,1,1,0,0,1);
      4'h4: s = seg_bits(0,1,1,0,0,1,1);
      4'h5: s = seg_bits(1,0,1,1,0,1,1);
      4'h6: s = seg_bits(1,0,1,1,1,1,1);
      4'h7: s = seg_bits(1,1,1,0,0,0,0);
      4'h8: s = seg_bits(1,1,1,1,1,1,1);
      4'h9: s = seg_bits(1,1,1,1,0,1,1);
      4'hA: s = seg_bits(1,1,1,0,1,1,1);
      4'hB: s = seg_bits(0,0,1,1,1,1,1);
      4'hC: s = seg_bits(1,0,0,1,1,1,0);
      4'hD: s = seg_bits(0,1,1,1,1,0,1);
      4'hE: s = seg_bits(1,0,0,1,1,1,1);
      default: s = seg_bits(1,0,0,0,1,1,1);
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sevensegment_scan.sv
// sevensegment_scan: multiplexed seven-segment driver
// double-buffered value, registered pin stage
module sevensegment_scan
  import sevensegment_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 100000,
  parameter int ACTIVE_LOW = 1,
  parameter int LZ_BLANK   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    blank_i,
  output logic [SEG_W-1:0]        seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o,
  output logic                    pending_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic LZ  = (LZ_BLANK != 0);

  localparam logic [DW-1:0] DIV_LAST =
    DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_DIGITS - 1);

  logic [DW-1:0] div_q;
  logic [IW-1:0] idx_q;
  logic          wrap_q;
  logic          div_tc;
  logic          bound;

  logic [4*NUM_DIGITS-1:0] act_val;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_q;

  logic [3:0]            nib;
  logic                  cur_dp;
  logic                  lead;
  logic                  acc;
  logic [NUM_DIGITS-1:0] an_n;
  logic [SEG_W-1:0]      seg_n;
  logic                  dp_n;
  logic [NUM_DIGITS-1:0] en_n;

  assign div_tc = (div_q == DIV_LAST);
  assign bound  = div_tc && (idx_q == IDX_LAST);

  // refresh divider and digit index; flag frame wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= bound;
      if (div_tc) begin
        div_q <= '0;
        if (idx_q == IDX_LAST) idx_q <= '0;
        else                   idx_q <= idx_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  // pending/active buffers; swap only at frame wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      act_val  <= '0;
      act_dp   <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend_q   <= 1'b0;
    end else if (bound) begin
      pend_q <= 1'b0;
      if (load_i) begin
        act_val <= value_i;
        act_dp  <= dp_i;
      end else if (pend_q) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
    end else if (load_i) begin
      pend_val <= value_i;
      pend_dp  <= dp_i;
      pend_q   <= 1'b1;
    end
  end

  // select current digit; track zeros from the top down
  always_comb begin
    nib    = '0;
    cur_dp = 1'b0;
    an_n   = '0;
    lead   = 1'b0;
    acc    = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc = acc & (act_val[4*k +: 4] == 4'h0);
      if (idx_q == IW'(k)) begin
        nib     = act_val[4*k +: 4];
        cur_dp  = act_dp[k];
        an_n[k] = 1'b1;
        lead    = acc && (k != 0);
      end
    end
  end

  // blanking and leading-zero suppression
  always_comb begin
    seg_n = hex2seg(nib);
    dp_n  = cur_dp;
    en_n  = an_n;
    if (LZ && lead) seg_n = '0;
    if (blank_i) begin
      seg_n = '0;
      dp_n  = 1'b0;
      en_n  = '0;
    end
  end

  // pin registers with polarity applied
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_o     <= {SEG_W{POL}};
      dp_o      <= POL;
      an_o      <= {NUM_DIGITS{POL}};
      frame_o   <= 1'b0;
      pending_o <= 1'b0;
    end else begin
      seg_o     <= seg_n ^ {SEG_W{POL}};
      dp_o      <= dp_n ^ POL;
      an_o      <= en_n ^ {NUM_DIGITS{POL}};
      frame_o   <= wrap_q;
      pending_o <= pend_q;
    end
  end

endmodule

// File: tb/tb_sevensegment_scan.sv
// tb_sevensegment_scan: random stimulus vs frame-level model
// two DUTs share inputs: plain active-high and active-low with LZ
module tb_sevensegment_scan;

  localparam int N  = 4;
  localparam int CD = 4;
  localparam int FR = N * CD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blank;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [3:0] an0, an1;
  logic       fr0, fr1;
  logic       pd0, pd1;

  sevensegment_scan #(
    .NUM_DIGITS(N), .CLK_DIV(CD),
    .ACTIVE_LOW(0), .LZ_BLANK(0)
  ) u0 (
    .clk(clk), .rst(rst), .value_i(value),
    .dp_i(dp), .load_i(load), .blank_i(blank),
    .seg_o(seg0), .dp_o(dp0), .an_o(an0),
    .frame_o(fr0), .pending_o(pd0)
  );

  sevensegment_scan #(
    .NUM_DIGITS(N), .CLK_DIV(CD),
    .ACTIVE_LOW(1), .LZ_BLANK(1)
  ) u1 (
    .clk(clk), .rst(rst), .value_i(value),
    .dp_i(dp), .load_i(load), .blank_i(blank),
    .seg_o(seg1), .dp_o(dp1), .an_o(an1),
    .frame_o(fr1), .pending_o(pd1)
  );

  always #5 clk = ~clk;

  logic [6:0] segtab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: edges since reset release and the two buffers
  int          e;
  logic [15:0] act, pact;
  logic [3:0]  adp, pdp;
  bit          pflag;

  logic [6:0] x_seg0, x_seg1;
  logic       x_dp0, x_dp1;
  logic [3:0] x_an0, x_an1;
  logic       x_fr, x_pd;

  task automatic cycle();
    int d;
    logic [3:0] nib;
    bit lzb;
    @(posedge clk);
    if (rst) begin
      e = 0; act = '0; pact = '0;
      adp = '0; pdp = '0; pflag = 0;
      x_seg0 = 7'h00; x_dp0 = 1'b0; x_an0 = 4'h0;
      x_seg1 = 7'h7F; x_dp1 = 1'b1; x_an1 = 4'hF;
      x_fr = 1'b0; x_pd = 1'b0;
    end else begin
      e++;
      d   = ((e - 1) / CD) % N;
      nib = 4'((act >> (4 * d)) & 16'hF);
      lzb = (d > 0) && ((act >> (4 * d)) == 0);
      x_fr = (e > 1) && ((e - 1) % FR == 0);
      x_pd = pflag;
      if (blank) begin
        x_seg0 = 7'h00; x_dp0 = 1'b0; x_an0 = 4'h0;
        x_seg1 = 7'h7F; x_dp1 = 1'b1; x_an1 = 4'hF;
      end else begin
        x_seg0 = segtab[nib];
        x_dp0  = adp[d];
        x_an0  = 4'(1 << d);
        x_seg1 = ~(lzb ? 7'h00 : segtab[nib]);
        x_dp1  = ~adp[d];
        x_an1  = ~x_an0;
      end
      if (e % FR == 0) begin
        if (load) begin
          act = value; adp = dp;
        end else if (pflag) begin
          act = pact; adp = pdp;
        end
        pflag = 0;
      end else if (load) begin
        pact = value; pdp = dp; pflag = 1;
      end
    end
    @(negedge clk);
    chk($sformatf("seg0@%0d", e), 32'(seg0), 32'(x_seg0));
    chk($sformatf("dp0@%0d", e),  32'(dp0),  32'(x_dp0));
    chk($sformatf("an0@%0d", e),  32'(an0),  32'(x_an0));
    chk($sformatf("frame0@%0d", e), 32'(fr0), 32'(x_fr));
    chk($sformatf("pend0@%0d", e),  32'(pd0), 32'(x_pd));
    chk($sformatf("seg1@%0d", e), 32'(seg1), 32'(x_seg1));
    chk($sformatf("dp1@%0d", e),  32'(dp1),  32'(x_dp1));
    chk($sformatf("an1@%0d", e),  32'(an1),  32'(x_an1));
    chk($sformatf("frame1@%0d", e), 32'(fr1), 32'(x_fr));
    chk($sformatf("pend1@%0d", e),  32'(pd1), 32'(x_pd));
  endtask

  function automatic logic [15:0] rnd_value();
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < 4; k++)
      if ($urandom_range(0, 1) == 1)
        v[4*k +: 4] = 4'($urandom);
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      load = 1'b0;
      cycle();
    end
  endtask

  task automatic load_once(input logic [15:0] v,
                           input logic [3:0] p);
    value = v; dp = p; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; value = '0; dp = '0;
    load = 1'b0; blank = 1'b0;
    e = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b0;

    load_once(16'h1234, 4'b0000);
    idle(3 * FR);

    idle(FR / 2);
    load_once(16'hABCD, 4'b0101);
    idle(2 * FR);

    while ((e + 1) % FR != 0) idle(1);
    load_once(16'h0050, 4'b1000);
    idle(2 * FR);

    while ((e + 1) % FR != 0) idle(1);
    load_once(16'h0000, 4'b0000);
    idle(FR + 3);

    blank = 1'b1;
    idle(7);
    blank = 1'b0;
    idle(FR);

    for (int i = 0; i < 700; i++) begin
      value = rnd_value();
      dp    = 4'($urandom);
      load  = ($urandom_range(0, 11) == 0) ||
              (((e + 1) % FR == 0) &&
               ($urandom_range(0, 1) == 0));
      if ($urandom_range(0, 39) == 0) blank = ~blank;
      cycle();
    end
    blank = 1'b0;
    load  = 1'b0;

    idle(5);
    load_once(16'h9876, 4'b1111);
    idle(2);
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    idle(3 * FR);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
